// File: rtl/tlb_fill_if.sv
// Bundle of miss, page-walk and TLB-entry signals around the TLB refill controller.
// The controller connects through the master modport; the lookup pipeline, walker
// and testbench side use the slave modport.
interface tlb_fill_if #(
  parameter int NUM_ENTRIES = 8,
  parameter int VPN_WIDTH   = 20,
  parameter int PFN_WIDTH   = 20
);
  logic                             miss_in;
  logic [VPN_WIDTH-1:0]             miss_vpn;
  logic                             flush;

  logic                             walk_req_valid;
  logic [VPN_WIDTH-1:0]             walk_req_vpn;
  logic                             walk_req_ready;

  logic                             walk_rsp_valid;
  logic [PFN_WIDTH-1:0]             walk_rsp_pf;
  logic                             walk_rsp_p;
  logic                             walk_rsp_rw;
  logic                             walk_rsp_pcd;
  logic                             walk_rsp_fault;

  logic [NUM_ENTRIES*VPN_WIDTH-1:0] VP;
  logic [NUM_ENTRIES*PFN_WIDTH-1:0] PF;
  logic [NUM_ENTRIES-1:0]           entry_v;
  logic [NUM_ENTRIES-1:0]           entry_P;
  logic [NUM_ENTRIES-1:0]           entry_RW;
  logic [NUM_ENTRIES-1:0]           entry_PCD;

  logic                             stall;
  logic                             fill_done;
  logic                             walk_fault;

  modport master (
    input  miss_in, miss_vpn, flush,
    output walk_req_valid, walk_req_vpn,
    input  walk_req_ready,
    input  walk_rsp_valid, walk_rsp_pf, walk_rsp_p, walk_rsp_rw, walk_rsp_pcd, walk_rsp_fault,
    output VP, PF, entry_v, entry_P, entry_RW, entry_PCD,
    output stall, fill_done, walk_fault
  );

  modport slave (
    output miss_in, miss_vpn, flush,
    input  walk_req_valid, walk_req_vpn,
    output walk_req_ready,
    output walk_rsp_valid, walk_rsp_pf, walk_rsp_p, walk_rsp_rw, walk_rsp_pcd, walk_rsp_fault,
    input  VP, PF, entry_v, entry_P, entry_RW, entry_PCD,
    input  stall, fill_done, walk_fault
  );
endinterface

// File: rtl/tlb_fill_ctrl.sv
// Refill and maintenance controller for the 8-entry fully associative MEM-stage TLB.
// Owns the entry storage, sequences page-walk request/response on a miss, picks a
// victim (tag hit, then lowest free, then round-robin) and handles global flush.
module tlb_fill_ctrl #(
  parameter int NUM_ENTRIES = 8,
  parameter int VPN_WIDTH   = 20,
  parameter int PFN_WIDTH   = 20
) (
  input  logic      clk,
  input  logic      rst,
  tlb_fill_if.master bus
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam logic [IDX_W-1:0] IDX_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WRITE
  } state_t;

  state_t                                 state;
  logic [VPN_WIDTH-1:0]                   req_vpn;
  logic [PFN_WIDTH-1:0]                   rsp_pf;
  logic                                   rsp_p;
  logic                                   rsp_rw;
  logic                                   rsp_pcd;
  logic                                   discard;
  logic [IDX_W-1:0]                       rr_ptr;

  logic [NUM_ENTRIES-1:0][VPN_WIDTH-1:0]  vp_mem;
  logic [NUM_ENTRIES-1:0][PFN_WIDTH-1:0]  pf_mem;
  logic [NUM_ENTRIES-1:0]                 v_q;
  logic [NUM_ENTRIES-1:0]                 p_q;
  logic [NUM_ENTRIES-1:0]                 rw_q;
  logic [NUM_ENTRIES-1:0]                 pcd_q;

  logic                                   walk_req_valid_q;
  logic                                   stall_q;
  logic                                   fill_done_q;
  logic                                   walk_fault_q;

  logic                                   hit_found;
  logic [IDX_W-1:0]                       hit_idx;
  logic                                   free_found;
  logic [IDX_W-1:0]                       free_idx;
  logic [IDX_W-1:0]                       victim;
  logic                                   use_rr;

  // Victim choice: an existing tag match avoids duplicates, otherwise the lowest
  // free slot, otherwise the round-robin pointer. Scanning downward lets the
  // lowest index win both searches.
  always_comb begin
    hit_found  = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    victim     = rr_ptr;
    use_rr     = 1'b0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (v_q[i] && (vp_mem[i] == req_vpn)) begin
        hit_found = 1'b1;
        hit_idx   = i[IDX_W-1:0];
      end
      if (!v_q[i]) begin
        free_found = 1'b1;
        free_idx   = i[IDX_W-1:0];
      end
    end
    if (hit_found) begin
      victim = hit_idx;
    end else if (free_found) begin
      victim = free_idx;
    end else begin
      victim = rr_ptr;
      use_rr = 1'b1;
    end
  end

  // Refill FSM together with the entry storage and all registered outputs. A flush
  // while a walk is outstanding marks the eventual response for discard, and a
  // flush arriving in the same cycle as the response drops it directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      req_vpn          <= '0;
      rsp_pf           <= '0;
      rsp_p            <= 1'b0;
      rsp_rw           <= 1'b0;
      rsp_pcd          <= 1'b0;
      discard          <= 1'b0;
      rr_ptr           <= '0;
      vp_mem           <= '0;
      pf_mem           <= '0;
      v_q              <= '0;
      p_q              <= '0;
      rw_q             <= '0;
      pcd_q            <= '0;
      walk_req_valid_q <= 1'b0;
      stall_q          <= 1'b0;
      fill_done_q      <= 1'b0;
      walk_fault_q     <= 1'b0;
    end else begin
      fill_done_q  <= 1'b0;
      walk_fault_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.flush) begin
            v_q <= '0;
          end else if (bus.miss_in) begin
            req_vpn          <= bus.miss_vpn;
            walk_req_valid_q <= 1'b1;
            stall_q          <= 1'b1;
            state            <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.flush) begin
            v_q     <= '0;
            discard <= 1'b1;
          end
          if (bus.walk_req_ready) begin
            walk_req_valid_q <= 1'b0;
            state            <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.flush) begin
            v_q     <= '0;
            discard <= 1'b1;
          end
          if (bus.walk_rsp_valid) begin
            if (discard || bus.flush) begin
              discard <= 1'b0;
              stall_q <= 1'b0;
              state   <= S_IDLE;
            end else if (bus.walk_rsp_fault) begin
              walk_fault_q <= 1'b1;
              stall_q      <= 1'b0;
              state        <= S_IDLE;
            end else begin
              rsp_pf  <= bus.walk_rsp_pf;
              rsp_p   <= bus.walk_rsp_p;
              rsp_rw  <= bus.walk_rsp_rw;
              rsp_pcd <= bus.walk_rsp_pcd;
              state   <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          vp_mem[victim] <= req_vpn;
          pf_mem[victim] <= rsp_pf;
          p_q[victim]    <= rsp_p;
          rw_q[victim]   <= rsp_rw;
          pcd_q[victim]  <= rsp_pcd;
          if (bus.flush) begin
            v_q <= '0;
          end else begin
            v_q[victim] <= 1'b1;
          end
          if (use_rr) begin
            rr_ptr <= rr_ptr + IDX_ONE;
          end
          fill_done_q <= 1'b1;
          stall_q     <= 1'b0;
          state       <= S_IDLE;
        end
        default: begin
          stall_q          <= 1'b0;
          walk_req_valid_q <= 1'b0;
          state            <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.walk_req_valid = walk_req_valid_q;
  assign bus.walk_req_vpn   = req_vpn;
  assign bus.VP             = vp_mem;
  assign bus.PF             = pf_mem;
  assign bus.entry_v        = v_q;
  assign bus.entry_P        = p_q;
  assign bus.entry_RW       = rw_q;
  assign bus.entry_PCD      = pcd_q;
  assign bus.stall          = stall_q;
  assign bus.fill_done      = fill_done_q;
  assign bus.walk_fault     = walk_fault_q;

endmodule

// File: tb/tb_tlb_fill_ctrl.sv
// Scoreboard bench for tlb_fill_ctrl: the stimulus process pushes the expected
// walk request and install/fault events, and a negedge monitor pops and checks
// them whenever the controller presents one.
module tb_tlb_fill_ctrl;

  typedef enum int {EV_REQ = 0, EV_FILL = 1, EV_FAULT = 2} ev_kind_t;

  typedef struct {
    ev_kind_t    kind;
    logic [19:0] vpn;
    logic [19:0] pf;
    logic        p;
    logic        rw;
    logic        pcd;
    int          idx;
    logic [7:0]  vmask;
  } ev_t;

  logic clk;
  logic rst;
  ev_t  exp_q[$];
  int   n_checks;
  int   n_fail;
  logic prev_req;

  tlb_fill_if bus ();

  tlb_fill_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the stimulus ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [159:0] actual,
                              input logic [159:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop the next expected event and compare it against what the DUT shows now
  task automatic handle_event(input ev_kind_t seen);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL unexpected_event: got kind %0d expected none", int'(seen));
      return;
    end
    e = exp_q.pop_front();
    check_output("event_kind", int'(seen), int'(e.kind));
    case (seen)
      EV_REQ: begin
        check_output("req_vpn", bus.walk_req_vpn, e.vpn);
      end
      EV_FILL: begin
        check_output("fill_entry_v", bus.entry_v, e.vmask);
        check_output("fill_vp", bus.VP[e.idx*20 +: 20], e.vpn);
        check_output("fill_pf", bus.PF[e.idx*20 +: 20], e.pf);
        check_output("fill_flags", {bus.entry_P[e.idx], bus.entry_RW[e.idx], bus.entry_PCD[e.idx]},
                     {e.p, e.rw, e.pcd});
        check_output("fill_stall", bus.stall, 1'b0);
      end
      default: begin
        check_output("fault_entry_v", bus.entry_v, e.vmask);
        check_output("fault_stall", bus.stall, 1'b0);
      end
    endcase
  endtask

  // Monitor: sample away from the active edge and score every presented event
  initial begin
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.walk_req_valid && !prev_req) handle_event(EV_REQ);
      if (bus.fill_done) handle_event(EV_FILL);
      if (bus.walk_fault) handle_event(EV_FAULT);
      prev_req = bus.walk_req_valid;
    end
  end

  // One complete miss: request, optional ready delay, optional flush in WAIT, response
  task automatic apply_stimulus(input logic [19:0] vpn, input int ready_delay,
                                input logic [19:0] pf, input logic p, input logic rw,
                                input logic pcd, input logic fault, input logic flush_in_wait,
                                input int exp_idx, input logic [7:0] exp_mask);
    ev_t e;
    int  waited;
    e.kind = EV_REQ; e.vpn = vpn; e.pf = '0; e.p = 0; e.rw = 0; e.pcd = 0;
    e.idx = 0; e.vmask = '0;
    exp_q.push_back(e);
    if (!flush_in_wait) begin
      e.kind  = fault ? EV_FAULT : EV_FILL;
      e.pf    = pf; e.p = p; e.rw = rw; e.pcd = pcd;
      e.idx   = exp_idx;
      e.vmask = exp_mask;
      exp_q.push_back(e);
    end

    bus.miss_in  = 1'b1;
    bus.miss_vpn = vpn;
    tick();
    bus.miss_in  = 1'b0;
    bus.miss_vpn = 20'hFFFFF;
    check_output("stall_after_miss", bus.stall, 1'b1);

    waited = 0;
    while (!bus.walk_req_valid && waited < 8) begin
      tick();
      waited++;
    end
    if (!bus.walk_req_valid) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL req_timeout: got valid 0 expected 1");
    end

    for (int k = 0; k < ready_delay; k++) begin
      tick();
      check_output("req_valid_hold", bus.walk_req_valid, 1'b1);
      check_output("req_vpn_hold", bus.walk_req_vpn, vpn);
    end

    bus.walk_req_ready = 1'b1;
    tick();
    bus.walk_req_ready = 1'b0;
    check_output("req_valid_drop", bus.walk_req_valid, 1'b0);

    if (flush_in_wait) begin
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check_output("flush_wait_v", bus.entry_v, 8'h00);
    end

    bus.walk_rsp_valid = 1'b1;
    bus.walk_rsp_pf    = pf;
    bus.walk_rsp_p     = p;
    bus.walk_rsp_rw    = rw;
    bus.walk_rsp_pcd   = pcd;
    bus.walk_rsp_fault = fault;
    tick();
    bus.walk_rsp_valid = 1'b0;
    bus.walk_rsp_fault = 1'b0;
    if (!fault && !flush_in_wait) begin
      check_output("stall_in_write", bus.stall, 1'b1);
      tick();
    end
    check_output("stall_back_idle", bus.stall, 1'b0);
  endtask

  initial begin
    ev_t e;
    n_checks = 0;
    n_fail   = 0;
    rst                = 1'b1;
    bus.miss_in        = 1'b0;
    bus.miss_vpn       = '0;
    bus.flush          = 1'b0;
    bus.walk_req_ready = 1'b0;
    bus.walk_rsp_valid = 1'b0;
    bus.walk_rsp_pf    = '0;
    bus.walk_rsp_p     = 1'b0;
    bus.walk_rsp_rw    = 1'b0;
    bus.walk_rsp_pcd   = 1'b0;
    bus.walk_rsp_fault = 1'b0;

    repeat (2) tick();
    check_output("reset_entry_v", bus.entry_v, 8'h00);
    check_output("reset_vp", bus.VP, 160'h0);
    check_output("reset_pf", bus.PF, 160'h0);
    check_output("reset_outs", {bus.stall, bus.walk_req_valid, bus.fill_done, bus.walk_fault}, 4'b0);
    rst = 1'b0;
    tick();

    // First fill with a slow walker
    apply_stimulus(20'h12345, 3, 20'hABCDE, 1, 1, 0, 0, 0, 0, 8'h01);

    // Fill the remaining seven entries in order
    for (int i = 1; i < 8; i++) begin
      apply_stimulus(20'h10000 + 20'(i), i % 2, 20'h20000 + 20'(i), 1, i[0], i[1],
                     0, 0, i, 8'((9'h1 << (i + 1)) - 9'h1));
    end

    // Table full: round-robin replaces entry 0, then entry 1
    apply_stimulus(20'h10008, 0, 20'h20008, 1, 0, 0, 0, 0, 0, 8'hFF);
    apply_stimulus(20'h10009, 1, 20'h20009, 1, 1, 1, 0, 0, 1, 8'hFF);

    // Resident tag in entry 3 is updated in place, pointer untouched
    apply_stimulus(20'h10003, 0, 20'h55555, 0, 1, 1, 0, 0, 3, 8'hFF);
    apply_stimulus(20'h1000A, 0, 20'h2000A, 1, 0, 1, 0, 0, 2, 8'hFF);

    // Faulted walk
    apply_stimulus(20'h30000, 2, 20'h77777, 1, 1, 1, 1, 0, 0, 8'hFF);

    // Flush while waiting: response dropped, then a normal fill into entry 0
    apply_stimulus(20'h40000, 0, 20'h88888, 1, 1, 0, 0, 1, 0, 8'h00);
    tick();
    check_output("post_flush_v", bus.entry_v, 8'h00);
    apply_stimulus(20'h40001, 0, 20'h99999, 1, 0, 0, 0, 0, 0, 8'h01);

    // Reset in WAIT aborts the refill asynchronously
    e.kind = EV_REQ; e.vpn = 20'h50000; e.pf = '0; e.p = 0; e.rw = 0; e.pcd = 0;
    e.idx = 0; e.vmask = '0;
    exp_q.push_back(e);
    bus.miss_in  = 1'b1;
    bus.miss_vpn = 20'h50000;
    tick();
    bus.miss_in = 1'b0;
    bus.walk_req_ready = 1'b1;
    tick();
    bus.walk_req_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_output("async_rst_v", bus.entry_v, 8'h00);
    check_output("async_rst_vp", bus.VP, 160'h0);
    check_output("async_rst_outs", {bus.stall, bus.walk_req_valid, bus.fill_done, bus.walk_fault}, 4'b0);
    tick();
    rst = 1'b0;
    tick();

    // Stray response in IDLE must be ignored
    bus.walk_rsp_valid = 1'b1;
    bus.walk_rsp_pf    = 20'hCAFE0;
    bus.walk_rsp_p     = 1'b1;
    tick();
    bus.walk_rsp_valid = 1'b0;
    repeat (2) tick();
    check_output("stray_rsp_v", bus.entry_v, 8'h00);
    check_output("stray_rsp_stall", bus.stall, 1'b0);

    repeat (2) tick();
    check_output("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tlb_fill_ctrl.md
Name: tlb_fill_ctrl

Overview:
Refill and maintenance controller for the 8-entry, fully associative MEM-stage TLB. It owns the TLB entry storage and drives the packed VP/PF/flag buses into the TLB lookup block. On a TLB miss it sequences a page-walk request/response handshake, selects a victim entry and writes the new translation. It also performs a global flush that invalidates all entries, and stalls the MEM stage while a refill is in flight.

Parameters:
NUM_ENTRIES, 8, TLB entries; fixed at 8, with a 3-bit index and 8-bit flag buses.
VPN_WIDTH, 20, virtual page number width (address[31:12]).
PFN_WIDTH, 20, physical frame number width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
miss_in  in  1  TLB lookup miss; qualified only in IDLE
miss_vpn  in  20  VPN of the missing access
flush  in  1  invalidate all entries (single-cycle pulse or level)
walk_req_valid  out  1  page-walk request valid
walk_req_vpn  out  20  VPN sent to the walker
walk_req_ready  in  1  walker accepts the request
walk_rsp_valid  in  1  walker response valid; only consumed in WAIT
walk_rsp_pf  in  20  PFN returned by the walker
walk_rsp_p  in  1  present bit
walk_rsp_rw  in  1  RW bit
walk_rsp_pcd  in  1  PCD bit
walk_rsp_fault  in  1  walk faulted; no install
VP  out  160  packed VPNs; entry i at [i*20+19:i*20]
PF  out  160  packed PFNs, same packing as VP
entry_v  out  8  valid bits
entry_P  out  8  present bits
entry_RW  out  8  RW bits
entry_PCD  out  8  PCD bits
stall  out  1  high when state != IDLE
fill_done  out  1  one-cycle pulse when an entry is installed
walk_fault  out  1  one-cycle pulse on a faulted response

Behaviour:
Reset (async):
- State = IDLE.
- All VP, PF, entry_* = 0.
- rr_ptr = 0; discard = 0.
- stall, walk_req_valid, fill_done, walk_fault = 0.

Storage and timing:
- All storage is registered; output buses are direct register outputs.
- A write becomes visible to lookups the cycle after WRITE.

States:
- IDLE
  - flush: clear all entry_v.
  - miss_in & !flush: latch miss_vpn into req_vpn, go to REQ.
  - miss_in & flush in the same cycle: flush only; stay IDLE. The pipeline re-looks-up and misses again.
- REQ
  - walk_req_valid = 1 and walk_req_vpn = req_vpn, held stable until walk_req_ready is sampled high.
  - On ready, go to WAIT. Valid drops the following cycle.
- WAIT
  - Wait for walk_rsp_valid, with no timeout.
  - Response with discard = 1: consume it, clear discard, go to IDLE, no pulses.
  - Response with fault = 1: pulse walk_fault, go to IDLE, no write.
  - Otherwise: capture the response fields and go to WRITE.
- WRITE (1 cycle)
  - Write VP = req_vpn, PF, P, RW, PCD into the victim entry and set entry_v = 1.
  - Pulse fill_done, go to IDLE.

Flush outside IDLE:
- In REQ or WAIT, flush clears all entry_v at once and sets discard.
- The handshake still completes, but the response is dropped.
- In WRITE, flush takes priority: all valid bits end at 0, including the entry being written, and fill_done still pulses.

Victim selection (evaluated in WRITE, priority order):
1. A valid entry whose VP equals req_vpn. Overwrite it, so there are never duplicate tags.
2. Otherwise, the lowest-index invalid entry.
3. Otherwise, the entry at rr_ptr; then rr_ptr = rr_ptr + 1 mod 8, wrapping from 7 to 0.
- rr_ptr advances only in case 3.

Other rules:
- miss_in is ignored outside IDLE.
- walk_rsp_valid is ignored outside WAIT.
- Reset mid-refill aborts immediately: all entries become invalid and walk_req_valid drops asynchronously.

Test Plan:
- Reset, then miss_vpn = 0x12345: expect walk_req_valid with vpn 0x12345. Hold ready low 3 cycles: valid and vpn stay stable. Ready, then response pf = 0xABCDE, p = 1, rw = 1: expect entry 0 with VP = 0x12345, PF = 0xABCDE, entry_v = 0x01, one fill_done pulse, and stall high from the cycle after the miss through WRITE.
- Nine fills with distinct VPNs: entries 0–7 fill in order. Fill 9 replaces entry 0 (rr_ptr 0 -> 1). Fill 10 replaces entry 1.
- Fill a VPN already resident in entry 3 with a new PF: entry 3 is updated, entry_v is unchanged, rr_ptr is unchanged.
- Response with walk_rsp_fault = 1: exactly one walk_fault pulse, no fill_done, entry_v unchanged, return to IDLE.
- All 8 entries valid; assert flush in WAIT, then respond: entry_v = 0x00, no install, no fill_done. Next miss proceeds normally and installs into entry 0.
- Assert rst during WAIT: all outputs return to 0 immediately. A subsequent stray walk_rsp_valid in IDLE has no effect.
